// File: rtl/debug_led_writer_if.sv
// Request/strobe bundle between LED-update producers and the debug LED writer.
// Latency: none (wires only).
// Backpressure: o_ready qualifies i_valid; the producer holds its request while o_ready is low.
interface debug_led_writer_if;
  logic       i_valid;
  logic       o_ready;
  logic [5:0] i_ledNo;
  logic [3:0] i_red;
  logic [3:0] i_green;
  logic [3:0] i_blue;
  logic       i_status;
  logic       i_clearAll;
  logic [18:0] o_debugInfo;
  logic       o_cs;
  logic       o_busy;

  modport master (
    output i_valid, i_ledNo, i_red, i_green, i_blue, i_status, i_clearAll,
    input  o_ready, o_debugInfo, o_cs, o_busy
  );

  modport slave (
    input  i_valid, i_ledNo, i_red, i_green, i_blue, i_status, i_clearAll,
    output o_ready, o_debugInfo, o_cs, o_busy
  );
endinterface

// File: rtl/debug_led_writer.sv
// Generic circular FIFO with wrap-bit pointers.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: in_rdy = !full; simultaneous push and pop leaves occupancy unchanged.
module fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Same index with opposite wrap bits means the write pointer lapped the read pointer.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = in_vld && !full;
  assign pop   = out_rdy && !empty;

  assign in_rdy  = !full;
  assign out_vld = !empty;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
  end
endmodule

// Buffers LED update requests and replays each as a framed active-low strobe to the VGA debug monitor.
// Latency: accept at edge 0, word out at edge 1, cs low from edge 1+SETUP for CS_LOW cycles.
// Backpressure: o_ready = !fifo_full; the clear sweep keeps accepting into the FIFO.
module debug_led_writer #(
  parameter int DEPTH         = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int CS_LOW_CYCLES = 2,
  parameter int HOLD_CYCLES   = 2
) (
  input logic              i_clk,
  input logic              i_reset,
  debug_led_writer_if.slave bus
);
  typedef struct packed {
    logic [5:0] led_no;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       status;
  } led_word_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(CS_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    sweep_idx_q, sweep_idx_d;
  logic          clear_pending_q, clear_pending_d;
  logic          clear_active_q, clear_active_d;
  led_word_t     dbg_q, dbg_d;
  logic          cs_q, cs_d;

  led_word_t     req_dat;
  led_word_t     head_dat;
  logic          head_vld;
  logic          head_pop;
  logic          fifo_rdy;

  function automatic led_word_t clear_word(input logic [5:0] idx);
    led_word_t w;
    w        = '0;
    w.led_no = idx;
    return w;
  endfunction

  assign req_dat = {bus.i_ledNo, bus.i_red, bus.i_green, bus.i_blue, bus.i_status};

  fifo #(
    .W     ($bits(led_word_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .core_clk (i_clk),
    .arst_n   (i_reset),
    .in_vld   (bus.i_valid),
    .in_rdy   (fifo_rdy),
    .in_dat   (req_dat),
    .out_vld  (head_vld),
    .out_rdy  (head_pop),
    .out_dat  (head_dat)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sweep_idx_q     <= '0;
      clear_pending_q <= 1'b0;
      clear_active_q  <= 1'b0;
      dbg_q           <= '0;
      cs_q            <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sweep_idx_q     <= sweep_idx_d;
      clear_pending_q <= clear_pending_d;
      clear_active_q  <= clear_active_d;
      dbg_q           <= dbg_d;
      cs_q            <= cs_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sweep_idx_d     = sweep_idx_q;
    clear_pending_d = clear_pending_q;
    clear_active_d  = clear_active_q;
    dbg_d           = dbg_q;
    head_pop        = 1'b0;

    // A clear request only arms when no sweep is queued or running.
    if (bus.i_clearAll && !clear_pending_q && !clear_active_q) clear_pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (clear_pending_q) begin
          clear_pending_d = 1'b0;
          clear_active_d  = 1'b1;
          sweep_idx_d     = 6'd0;
          dbg_d           = clear_word(6'd0);
          state_d         = SETUP;
          cnt_d           = SETUP_LOAD;
        end else if (head_vld) begin
          head_pop = 1'b1;
          dbg_d    = head_dat;
          state_d  = SETUP;
          cnt_d    = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          // Mid-sweep words chain straight into the next SETUP without an idle cycle.
          if (clear_active_q && sweep_idx_q != 6'd63) begin
            sweep_idx_d = sweep_idx_q + 6'd1;
            dbg_d       = clear_word(sweep_idx_q + 6'd1);
            state_d     = SETUP;
            cnt_d       = SETUP_LOAD;
          end else begin
            clear_active_d = 1'b0;
            state_d        = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_d = (state_d != STROBE);
  end

  assign bus.o_ready     = fifo_rdy;
  assign bus.o_debugInfo = dbg_q;
  assign bus.o_cs        = cs_q;
  assign bus.o_busy      = head_vld || (state_q != IDLE) || clear_pending_q || clear_active_q;
endmodule

// File: tb/tb_debug_led_writer.sv
// Bench for debug_led_writer: directed requests and clear sweeps against a queue-based model of accepted writes.
module tb_debug_led_writer;
  logic i_clk;
  logic i_reset;
  debug_led_writer_if bus();

  debug_led_writer #(
    .DEPTH         (4),
    .SETUP_CYCLES  (2),
    .CS_LOW_CYCLES (2),
    .HOLD_CYCLES   (2)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: accepted requests in order, plus the remaining words of a requested sweep.
  logic [18:0] exp_q[$];
  int          clear_left = 0;
  logic        prev_cs    = 1'b1;
  logic [18:0] latched    = '0;
  int          fall_cnt   = 0;
  int          fall_cyc[$];
  logic [18:0] fall_dat[$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Compare process: every falling cs must carry the next modelled word, and the word must not move while cs is low.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      exp_q.delete();
      clear_left = 0;
      prev_cs    = 1'b1;
    end else begin
      if (prev_cs && !bus.o_cs) begin
        fall_cnt++;
        fall_cyc.push_back(cyc);
        fall_dat.push_back(bus.o_debugInfo);
        if (clear_left > 0) begin
          chk("sb_clear_word", {13'd0, bus.o_debugInfo}, {13'd0, 6'(64 - clear_left), 13'd0});
          clear_left--;
        end else if (exp_q.size() == 0) begin
          chk("sb_unexpected_strobe", {13'd0, bus.o_debugInfo}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_req_word", {13'd0, bus.o_debugInfo}, {13'd0, exp_q.pop_front()});
        end
        latched = bus.o_debugInfo;
      end else if (!prev_cs && !bus.o_cs) begin
        chk("cs_low_stable", {13'd0, bus.o_debugInfo}, {13'd0, latched});
      end
      prev_cs = bus.o_cs;
      if (bus.i_valid && bus.o_ready)
        exp_q.push_back({bus.i_ledNo, bus.i_red, bus.i_green, bus.i_blue, bus.i_status});
      if (bus.i_clearAll && clear_left == 0) clear_left = 64;
    end
  end

  task automatic send_req(input logic [5:0] led, input logic [3:0] r, input logic [3:0] g,
                          input logic [3:0] b, input logic s, output int stalls);
    bus.i_valid  = 1'b1;
    bus.i_ledNo  = led;
    bus.i_red    = r;
    bus.i_green  = g;
    bus.i_blue   = b;
    bus.i_status = s;
    stalls = 0;
    while (!bus.o_ready && stalls < 50) begin
      tick();
      stalls++;
    end
    if (!bus.o_ready) chk("send_ready_timeout", 32'(bus.o_ready), 32'd1);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (bus.o_busy && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int base;
    int t_start;
    int f0;
    i_reset        = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_ledNo    = '0;
    bus.i_red      = '0;
    bus.i_green    = '0;
    bus.i_blue     = '0;
    bus.i_status   = 1'b0;
    bus.i_clearAll = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_cs", 32'(bus.o_cs), 32'd1);
    chk("rst_dbg", {13'd0, bus.o_debugInfo}, 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    i_reset = 1'b1;
    tick();

    // Single write: LED 5 full red, lit.
    send_req(6'd5, 4'hF, 4'h0, 4'h0, 1'b1, st);
    chk("t1_busy_e0", 32'(bus.o_busy), 32'd1);
    tick();
    chk("t1_dbg_e1", {13'd0, bus.o_debugInfo}, 32'h0BE01);
    chk("t1_cs_e1", 32'(bus.o_cs), 32'd1);
    tick(); chk("t1_cs_e2", 32'(bus.o_cs), 32'd1);
    tick(); chk("t1_cs_e3", 32'(bus.o_cs), 32'd0);
    tick(); chk("t1_cs_e4", 32'(bus.o_cs), 32'd0);
    tick(); chk("t1_cs_e5", 32'(bus.o_cs), 32'd1);
    tick(); chk("t1_busy_e6", 32'(bus.o_busy), 32'd1);
    tick(); chk("t1_busy_e7", 32'(bus.o_busy), 32'd0);

    // Six back-to-back writes: FIFO fills after the first pop, last request stalls 4 cycles.
    base = fall_cyc.size();
    for (int i = 0; i < 6; i++) begin
      send_req(6'(10 + i), 4'(i), 4'(i + 1), 4'(i + 2), i[0], st);
      if (i == 4) chk("t2_ready_full", 32'(bus.o_ready), 32'd0);
      if (i == 5) chk("t2_stalls", st, 32'd4);
    end
    wait_idle("t2_idle", 100);
    chk("t2_strobes", fall_cyc.size() - base, 32'd6);
    for (int k = 1; k < 6 && base + k < fall_cyc.size(); k++)
      chk("t2_gap", fall_cyc[base + k] - fall_cyc[base + k - 1], 32'd7);

    // Clear sweep with two queued writes and a redundant clear pulse mid-sweep.
    base = fall_dat.size();
    f0   = fall_cnt;
    bus.i_clearAll = 1'b1;
    send_req(6'd20, 4'h1, 4'h2, 4'h3, 1'b1, st);
    bus.i_clearAll = 1'b0;
    t_start = cyc;
    send_req(6'd21, 4'hA, 4'hB, 4'hC, 1'b0, st);
    repeat (100) tick();
    bus.i_clearAll = 1'b1;
    tick();
    bus.i_clearAll = 1'b0;
    wait_idle("t3_idle", 1000);
    chk("t3_duration", cyc - t_start, 32'd399);
    chk("t3_strobes", fall_cnt - f0, 32'd66);
    if (fall_dat.size() >= base + 66) begin
      chk("t3_first_clear", {13'd0, fall_dat[base]}, 32'h00000);
      chk("t3_second_clear", {13'd0, fall_dat[base + 1]}, 32'h02000);
      chk("t3_last_clear", {13'd0, fall_dat[base + 63]}, 32'h7E000);
      chk("t3_after_req", {13'd0, fall_dat[base + 65]}, 32'h2B578);
    end else begin
      chk("t3_fall_record", fall_dat.size() - base, 32'd66);
    end

    // Reset while cs is low, with one request still in the FIFO.
    send_req(6'd30, 4'h3, 4'h3, 4'h3, 1'b1, st);
    send_req(6'd31, 4'h4, 4'h4, 4'h4, 1'b1, st);
    st = 0;
    while (bus.o_cs && st < 20) begin
      tick();
      st++;
    end
    chk("t4_cs_low_reached", 32'(bus.o_cs), 32'd0);
    f0 = fall_cnt;
    #2;
    i_reset = 1'b0;
    #1;
    chk("t4_cs_async", 32'(bus.o_cs), 32'd1);
    chk("t4_busy_in_rst", 32'(bus.o_busy), 32'd0);
    tick();
    chk("t4_dbg_in_rst", {13'd0, bus.o_debugInfo}, 32'd0);
    i_reset = 1'b1;
    repeat (10) tick();
    chk("t4_busy_after", 32'(bus.o_busy), 32'd0);
    chk("t4_ready_after", 32'(bus.o_ready), 32'd1);
    chk("t4_no_extra_fall", fall_cnt - f0, 32'd0);

    // Alternate LED 63 and LED 0 for 3*DEPTH entries to wrap the pointers.
    f0 = fall_cnt;
    for (int i = 0; i < 12; i++)
      send_req(i[0] ? 6'd0 : 6'd63, 4'(i), 4'(15 - i), 4'(i + 3), i[0], st);
    wait_idle("t5_idle", 300);
    chk("t5_strobes", fall_cnt - f0, 32'd12);

    chk("model_drained", exp_q.size(), 32'd0);
    chk("model_sweep_done", clear_left, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
